spi_height_loader: RTL
======================

SPI_HEIGHT_LOADER -- requirements
Module: spi_height_loader

Interface
REQ-001 SHALL have parameter: NCOLS, 64, number of panel columns (bars) per frame.
REQ-002 SHALL have parameter: HWID, 6, bit width of one column height.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: spi_sck  input  1  MCU SPI clock, asynchronous to clk, mode 0.
REQ-006 SHALL have port: spi_cs_n  input  1  MCU chip select, active-low, frames a transfer.
REQ-007 SHALL have port: spi_mosi  input  1  MCU serial data, MSB first.
REQ-008 SHALL have port: y_out  output  NCOLS x HWID  committed column heights, drives EBRController y_in.
REQ-009 SHALL have port: w_enable  output  1  one-cycle strobe: y_out has just been updated, write to EBR.
REQ-010 SHALL have port: busy  output  1  high while a frame is being received (synchronized CS low).
REQ-011 SHALL have port: frame_err  output  1  one-cycle strobe: last frame rejected.

Function
REQ-012 SHALL pass spi_sck, spi_cs_n, spi_mosi through 2-flop synchronizers before any use; spi_sck rising edge detected from synchronized samples.
REQ-013 SHALL sample synchronized spi_mosi on each detected spi_sck rising edge while synchronized CS is low; spi_sck frequency SHALL be <= clk/8.
REQ-014 SHALL assemble 8-bit bytes MSB first; byte k (k = 0..NCOLS-1) SHALL land in shadow column k, low HWID bits kept, upper bits discarded.
REQ-015 SHALL keep byte counter saturating at NCOLS+1 and bit counter 0..7 wrapping; both cleared on synchronized CS falling edge.
REQ-016 SHALL implement FSM states IDLE, RECV, CHECK: IDLE->RECV on synced CS fall; RECV->CHECK on synced CS rise; CHECK->IDLE always after one cycle.
REQ-017 In CHECK, frame valid iff byte count == NCOLS and bit count == 0; valid -> shadow copied to y_out and w_enable high on the next cycle only.
REQ-018 Invalid frame (short, long, partial byte) -> frame_err high one cycle, y_out unchanged, no w_enable.
REQ-019 Bytes beyond NCOLS SHALL not write shadow storage.
REQ-020 A spi_sck edge detected in the same cycle as synced CS rise SHALL be ignored.
REQ-021 CS falling again while in CHECK SHALL be taken in IDLE the following cycle; no SPI edge lost given REQ-013 rate.
REQ-022 busy SHALL equal (state == RECV); w_enable and frame_err SHALL never assert together.
REQ-023 Latency: w_enable asserts exactly 2 clk cycles after the cycle synced CS is first seen high.

Reset
REQ-024 reset low SHALL asynchronously force IDLE, counters 0, shadow and y_out all 0, w_enable/frame_err/busy 0, synchronizer flops to CS high, sck low, mosi 0.
REQ-025 reset asserted mid-frame SHALL discard partial frame; after release, reception restarts only on a fresh CS falling edge.

Structure
REQ-026 NCOLS, HWID defaults and the state enum SHALL live in shared package display_pkg.
REQ-027 One sub-module sync2 (2-flop synchronizer, async active-low reset, reset-value parameter) SHALL be instantiated per SPI input.
REQ-028 Shadow and output storage SHALL be flops, not EBR.

Verification
REQ-029 Valid frame bytes 0x00..0x3F -> y_out[k]=k, one w_enable pulse, frame_err 0.
REQ-030 Frame of 63 bytes -> frame_err pulse, y_out keeps prior values, no w_enable.
REQ-031 Frame of 65 bytes 0xFF -> frame_err pulse, y_out unchanged; next valid frame of all 0x2A -> all y_out = 42.
REQ-032 64 bytes plus 3 extra bits -> frame_err pulse, no w_enable.
REQ-033 reset pulsed low after 20 bytes -> all outputs 0 immediately; subsequent valid frame of all 0xC5 -> y_out all 0x05.
REQ-034 Back-to-back valid frames with 2-clk CS high gap -> two w_enable pulses, second y_out matches second frame.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display height-loading path.
//   NCOLS_DEF : default number of panel columns per frame
//   HWID_DEF  : default bit width of one column height
//   state_t   : frame receiver state encoding
package display_pkg;

  localparam int NCOLS_DEF = 64;
  localparam int HWID_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
//   clk   : destination clock
//   reset : asynchronous active-low reset, forces both flops to RST_VAL
//   i_d   : asynchronous input
//   o_q   : synchronized output (registered)
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/spi_height_loader.sv
// Receives one frame of column heights from an MCU over SPI (mode 0, MSB
// first, one byte per column) and commits it to y_out only when exactly
// NCOLS whole bytes arrived while chip select was low.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   spi_sck   : SPI clock (async, <= clk/8)
//   spi_cs_n  : SPI chip select, active low
//   spi_mosi  : SPI data
//   y_out     : committed column heights, column k at y_out[k]
//   w_enable  : one-cycle strobe when y_out has just been updated
//   busy      : high while a frame is being received
//   frame_err : one-cycle strobe when a frame was rejected
module spi_height_loader
  import display_pkg::*;
#(
  parameter int NCOLS = NCOLS_DEF,
  parameter int HWID  = HWID_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       spi_sck,
  input  logic                       spi_cs_n,
  input  logic                       spi_mosi,
  output logic [NCOLS-1:0][HWID-1:0] y_out,
  output logic                       w_enable,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int               BCW        = $clog2(NCOLS + 2);
  localparam int               IDW        = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam logic [BCW-1:0]   BYTES_FULL = BCW'(NCOLS);
  localparam logic [BCW-1:0]   BYTES_SAT  = BCW'(NCOLS + 1);

  logic                       w_sck_s, w_cs_s, w_mosi_s;
  logic                       r_sck_d, r_cs_d;
  logic [1:0]                 r_flush;
  logic                       w_armed;
  logic                       w_sck_rise, w_cs_fall, w_cs_rise, w_rx_en;
  state_t                     r_state, w_next;
  logic                       r_pend;
  logic [2:0]                 r_bit_cnt;
  logic [BCW-1:0]             r_byte_cnt;
  logic [HWID-2:0]            r_shift;
  logic [HWID-1:0]            w_col;
  logic                       w_frame_ok;
  logic [NCOLS-1:0][HWID-1:0] r_shadow;

  sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset(reset), .i_d(spi_sck),  .o_q(w_sck_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .i_d(spi_cs_n), .o_q(w_cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .i_d(spi_mosi), .o_q(w_mosi_s));

  // Edges are ignored until the synchronizers hold real samples, so a CS
  // already low at reset release never looks like a fresh frame start.
  assign w_armed    = (r_flush == 2'd3);
  assign w_sck_rise = w_armed & w_sck_s & ~r_sck_d;
  assign w_cs_fall  = w_armed & r_cs_d & ~w_cs_s;
  assign w_cs_rise  = w_armed & ~r_cs_d & w_cs_s;
  // Requiring CS low also drops an SCK edge coinciding with the CS rise.
  assign w_rx_en    = w_sck_rise & ~w_cs_s & ((r_state == RECV) | r_pend);
  // Only the low HWID bits are shifted, so upper byte bits fall off the top.
  assign w_col      = {r_shift, w_mosi_s};
  assign w_frame_ok = (r_byte_cnt == BYTES_FULL) & (r_bit_cnt == 3'd0);
  assign busy       = (r_state == RECV);

  // Edge-detect history and post-reset synchronizer flush counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_d <= 1'b0;
      r_cs_d  <= 1'b1;
      r_flush <= 2'd0;
    end else begin
      r_sck_d <= w_sck_s;
      r_cs_d  <= w_cs_s;
      if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
      else                 r_flush <= r_flush;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cs_fall || r_pend) w_next = RECV;
        else                     w_next = IDLE;
      end
      RECV: begin
        if (w_cs_rise) w_next = CHECK;
        else           w_next = RECV;
      end
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Remember a CS fall seen during CHECK so IDLE still starts the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               r_pend <= 1'b0;
    else if ((r_state == CHECK) && w_cs_fall) r_pend <= 1'b1;
    else if (r_state == IDLE)                 r_pend <= 1'b0;
    else                                      r_pend <= r_pend;
  end

  // Bit/byte counters and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (w_cs_fall) begin
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
      r_shift    <= r_shift;
    end else if (w_rx_en) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= w_col[HWID-2:0];
      if ((r_bit_cnt == 3'd7) && (r_byte_cnt != BYTES_SAT)) r_byte_cnt <= r_byte_cnt + BCW'(1);
      else                                                  r_byte_cnt <= r_byte_cnt;
    end else begin
      r_bit_cnt  <= r_bit_cnt;
      r_byte_cnt <= r_byte_cnt;
      r_shift    <= r_shift;
    end
  end

  // Shadow column write on each completed in-range byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (w_rx_en && (r_bit_cnt == 3'd7) && (r_byte_cnt < BYTES_FULL)) begin
      r_shadow[r_byte_cnt[IDW-1:0]] <= w_col;
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Frame verdict: commit shadow or flag an error, strobes last one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_out     <= '0;
      w_enable  <= 1'b0;
      frame_err <= 1'b0;
    end else if (r_state == CHECK) begin
      if (w_frame_ok) begin
        y_out     <= r_shadow;
        w_enable  <= 1'b1;
        frame_err <= 1'b0;
      end else begin
        y_out     <= y_out;
        w_enable  <= 1'b0;
        frame_err <= 1'b1;
      end
    end else begin
      y_out     <= y_out;
      w_enable  <= 1'b0;
      frame_err <= 1'b0;
    end
  end

endmodule
